// File: rtl/y_pixel_filling.sv
// Vertical single-pixel gap filler for the edge map held in frame RAM.
// Walks START_ADDR..END_ADDR in place: read centre, above, below, then write.
module y_pixel_filling #(
  parameter int          IMG_WIDTH  = 320,
  parameter int          START_ADDR = 2240,
  parameter int          END_ADDR   = 74560,
  parameter logic [31:0] FILL_VALUE = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pause,
  input  logic        enable_y_pixel_filling,
  input  logic [31:0] data_read,
  output logic        wren,
  output logic [31:0] data_write,
  output logic [17:0] address,
  output logic        y_pixel_filling_done,
  output logic [17:0] filled_count
);

  localparam logic [17:0] W     = 18'(IMG_WIDTH);
  localparam logic [17:0] START = 18'(START_ADDR);
  localparam logic [17:0] LAST  = 18'(END_ADDR);
  localparam logic [17:0] MAXC  = '1;

  typedef enum logic [2:0] {
    IDLE, RD_C, RD_A, RD_B, CALC, WR, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] p_q, p_d;
  logic [31:0] center_q, center_d;
  logic [31:0] above_q, above_d;
  logic        wren_q, wren_d;
  logic [31:0] data_q, data_d;
  logic [17:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic [17:0] cnt_q, cnt_d;
  logic [31:0] result;

  // data_read carries the below neighbour during CALC
  always_comb begin
    result = center_q;
    if (above_q == FILL_VALUE && data_read == FILL_VALUE)
      result = FILL_VALUE;
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    center_d = center_q;
    above_d  = above_q;
    wren_d   = wren_q;
    data_d   = data_q;
    addr_d   = addr_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    if (!pause) begin
      if (!enable_y_pixel_filling) begin
        state_d = IDLE;
        wren_d  = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        done_d  = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            p_d     = START;
            cnt_d   = '0;
            addr_d  = START;
            wren_d  = 1'b0;
            done_d  = 1'b0;
            state_d = RD_C;
          end
          RD_C: begin
            addr_d  = p_q - W;
            state_d = RD_A;
          end
          RD_A: begin
            center_d = data_read;
            addr_d   = p_q + W;
            state_d  = RD_B;
          end
          RD_B: begin
            above_d = data_read;
            state_d = CALC;
          end
          CALC: begin
            addr_d  = p_q;
            wren_d  = 1'b1;
            data_d  = result;
            if (result == FILL_VALUE &&
                center_q != FILL_VALUE &&
                cnt_q != MAXC)
              cnt_d = cnt_q + 18'd1;
            state_d = WR;
          end
          WR: begin
            wren_d = 1'b0;
            if (p_q == LAST) begin
              addr_d  = '0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              p_d     = p_q + 18'd1;
              addr_d  = p_q + 18'd1;
              state_d = RD_C;
            end
          end
          DONE: begin
            wren_d = 1'b0;
            addr_d = '0;
            done_d = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      p_q      <= '0;
      center_q <= '0;
      above_q  <= '0;
      wren_q   <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      center_q <= center_d;
      above_q  <= above_d;
      wren_q   <= wren_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wren                 = wren_q;
  assign data_write           = data_q;
  assign address              = addr_q;
  assign y_pixel_filling_done = done_q;
  assign filled_count         = cnt_q;

endmodule

// File: tb/tb_y_pixel_filling.sv
// Bench for y_pixel_filling: 8-wide, 64-word RAM, golden in-place model.
// Expected writes are queued from the model and matched against observed writes.
module tb_y_pixel_filling;

  localparam int W  = 8;
  localparam int SA = 8;
  localparam int EA = 55;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pause;
  logic        enable;
  logic [31:0] data_read;
  logic        wren;
  logic [31:0] data_write;
  logic [17:0] address;
  logic        done;
  logic [17:0] filled_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [17:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] gm  [0:63];
  int          exp_cnt;
  logic        wren_prev = 1'b0;

  always #5 clk = ~clk;

  y_pixel_filling #(
    .IMG_WIDTH (W),
    .START_ADDR(SA),
    .END_ADDR  (EA),
    .FILL_VALUE(32'd1)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .pause                 (pause),
    .enable_y_pixel_filling(enable),
    .data_read             (data_read),
    .wren                  (wren),
    .data_write            (data_write),
    .address               (address),
    .y_pixel_filling_done  (done),
    .filled_count          (filled_count)
  );

  always @(posedge clk) begin
    if (wren) mem[address[5:0]] <= data_write;
    data_read <= mem[address[5:0]];
  end

  always @(negedge clk) begin
    if (wren && !wren_prev) begin
      wr_t w;
      w.a = address;
      w.d = data_write;
      obs_q.push_back(w);
    end
    wren_prev = wren;
  end

  task automatic gold();
    logic [31:0] c, a, b, r;
    wr_t w;
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < 64; i++) gm[i] = mem[i];
    for (int p = SA; p <= EA; p++) begin
      c = gm[p];
      a = gm[p-W];
      b = gm[p+W];
      r = (a == 32'd1 && b == 32'd1) ? 32'd1 : c;
      if (r == 32'd1 && c != 32'd1) exp_cnt++;
      gm[p] = r;
      w.a = 18'(p);
      w.d = r;
      exp_q.push_back(w);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic run_pass(input int budget, output int cyc,
                          output bit to);
    enable = 1'b1;
    cyc = 0;
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic stop_pass();
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_mem();
    enable = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wren !== 1'b0 || address !== 18'd0 || done !== 1'b0 ||
        filled_count !== 18'd0 || data_write !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold wren=%b addr=%0d done=%b cnt=%0d dw=%0d",
               wren, address, done, filled_count, data_write);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (address !== 18'd8 || wren !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_rdc addr=%0d wren=%b want addr=8 wren=0",
               address, wren);
    end
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (address !== 18'd0 || wren !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async addr=%0d wren=%b done=%b want 0",
               address, wren, done);
    end
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gap();
    int cyc;
    bit to;
    wr_t e, o;
    clear_mem();
    mem[12] = 32'd1;
    mem[20] = 32'd0;
    mem[28] = 32'd1;
    gold();
    obs_q.delete();
    run_pass(400, cyc, to);
    checks++;
    if (to || cyc != 241) begin
      failures++;
      $display("FAIL gap_done_cycle got=%0d timeout=%b want=241", cyc, to);
    end
    checks++;
    if (mem[20] !== 32'd1 || filled_count < 18'd1) begin
      failures++;
      $display("FAIL gap_fill mem20=%0d cnt=%0d want 1 >=1",
               mem[20], filled_count);
    end
    checks++;
    if (filled_count !== 18'(exp_cnt)) begin
      failures++;
      $display("FAIL gap_count got=%0d want=%0d", filled_count, exp_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL gap_write missing want a=%0d d=%0d", e.a, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL gap_write got a=%0d d=%0d want a=%0d d=%0d",
                   o.a, o.d, e.a, e.d);
        end
      end
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== gm[i]) begin
        failures++;
        $display("FAIL gap_mem[%0d] got=%0d want=%0d", i, mem[i], gm[i]);
      end
    end
    stop_pass();
  endtask

  task automatic test_no_fill();
    int cyc;
    bit to;
    clear_mem();
    mem[12] = 32'd1;
    mem[28] = 32'd0;
    mem[20] = 32'd7;
    run_pass(400, cyc, to);
    checks++;
    if (to || mem[20] !== 32'd7 || filled_count !== 18'd0) begin
      failures++;
      $display("FAIL nofill_keep mem20=%0d cnt=%0d to=%b want 7 0",
               mem[20], filled_count, to);
    end
    stop_pass();
    clear_mem();
    run_pass(400, cyc, to);
    checks++;
    if (to || filled_count !== 18'd0) begin
      failures++;
      $display("FAIL nofill_zero_cnt got=%0d to=%b want=0",
               filled_count, to);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== 32'd0) begin
        failures++;
        $display("FAIL nofill_mem[%0d] got=%0d want=0", i, mem[i]);
      end
    end
    stop_pass();
  endtask

  task automatic test_pause();
    logic [17:0] s_addr, s_cnt;
    logic        s_wren;
    logic [31:0] s_dw;
    bit          fin;
    wr_t         e, o;
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'd1;
    mem[5] = 32'd3;
    gold();
    obs_q.delete();
    enable = 1'b1;
    repeat (54) @(posedge clk);
    @(negedge clk);
    checks++;
    if (address !== 18'(SA + 10 + W) || wren !== 1'b0) begin
      failures++;
      $display("FAIL pause_calc_addr got=%0d wren=%b want=%0d 0",
               address, wren, SA + 10 + W);
    end
    s_addr = address;
    s_wren = wren;
    s_dw = data_write;
    s_cnt = filled_count;
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (address !== s_addr || wren !== s_wren ||
          data_write !== s_dw || filled_count !== s_cnt) begin
        failures++;
        $display("FAIL pause_frozen cyc=%0d addr=%0d/%0d wren=%b/%b",
                 k, address, s_addr, wren, s_wren);
      end
    end
    pause = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      fin = done;
    end
    checks++;
    if (!fin || filled_count !== 18'(exp_cnt)) begin
      failures++;
      $display("FAIL pause_done done=%b cnt=%0d want 1 %0d",
               fin, filled_count, exp_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL pause_write missing want a=%0d", e.a);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL pause_write got a=%0d d=%0d want a=%0d d=%0d",
                   o.a, o.d, e.a, e.d);
        end
      end
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== gm[i]) begin
        failures++;
        $display("FAIL pause_mem[%0d] got=%0d want=%0d", i, mem[i], gm[i]);
      end
    end
    stop_pass();
  endtask

  task automatic test_abort_rerun();
    int cyc;
    bit to;
    for (int i = 0; i < 64; i++)
      mem[i] = ((i % 3) == 0) ? 32'd1 : 32'd0;
    enable = 1'b1;
    repeat (151) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wren !== 1'b0 || done !== 1'b0 || address !== 18'd0) begin
      failures++;
      $display("FAIL abort_idle wren=%b done=%b addr=%0d want 0 0 0",
               wren, done, address);
    end
    @(negedge clk);
    gold();
    obs_q.delete();
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (address !== 18'd8) begin
      failures++;
      $display("FAIL rerun_start addr=%0d want=8", address);
    end
    run_pass(400, cyc, to);
    checks++;
    if (to || filled_count !== 18'(exp_cnt)) begin
      failures++;
      $display("FAIL rerun_done to=%b cnt=%0d want=%0d",
               to, filled_count, exp_cnt);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== gm[i]) begin
        failures++;
        $display("FAIL rerun_mem[%0d] got=%0d want=%0d", i, mem[i], gm[i]);
      end
    end
    stop_pass();
  endtask

  task automatic test_cascade();
    int cyc;
    bit to;
    wr_t e, o;
    clear_mem();
    mem[8]  = 32'd1;
    mem[24] = 32'd1;
    mem[40] = 32'd1;
    mem[56] = 32'd1;
    mem[9]  = 32'd1;
    mem[25] = 32'd1;
    mem[33] = 32'd1;
    mem[49] = 32'd1;
    mem[18] = 32'd1;
    mem[34] = 32'd9;
    mem[26] = 32'd1;
    gold();
    obs_q.delete();
    run_pass(400, cyc, to);
    checks++;
    if (to || filled_count !== 18'(exp_cnt)) begin
      failures++;
      $display("FAIL cascade_count to=%b got=%0d want=%0d",
               to, filled_count, exp_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL cascade_write missing want a=%0d", e.a);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL cascade_write got a=%0d d=%0d want a=%0d d=%0d",
                   o.a, o.d, e.a, e.d);
        end
      end
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== gm[i]) begin
        failures++;
        $display("FAIL cascade_mem[%0d] got=%0d want=%0d",
                 i, mem[i], gm[i]);
      end
    end
    stop_pass();
  endtask

  initial begin
    rst_n = 1'b0;
    pause = 1'b0;
    enable = 1'b0;
    clear_mem();
    @(negedge clk);
    test_reset();
    test_gap();
    test_no_fill();
    test_pause();
    test_abort_rerun();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
